// File: rtl/microseq_pkg.sv
// Shared encodings for the microsequencer control block: op codes, Am2909 source selects,
// microword field offsets and the decoded control bundle.
package microseq_pkg;

    localparam int ADDR_W   = 12;
    localparam int UW_W     = 56;
    localparam int NCOND    = 16;

    localparam int OP_LSB   = 0;
    localparam int CSEL_LSB = 4;
    localparam int CPOL_BIT = 8;
    localparam int BR_LSB   = 9;
    localparam int CTRL_LSB = 21;

    typedef enum logic [3:0] {
        OP_JZ   = 4'd0,  OP_CJS  = 4'd1,  OP_JMAP = 4'd2,  OP_CJP  = 4'd3,
        OP_PUSH = 4'd4,  OP_JSRP = 4'd5,  OP_CJV  = 4'd6,  OP_JRP  = 4'd7,
        OP_RFCT = 4'd8,  OP_RPCT = 4'd9,  OP_CRTN = 4'd10, OP_CJPP = 4'd11,
        OP_LDCT = 4'd12, OP_LOOP = 4'd13, OP_CONT = 4'd14, OP_TWB  = 4'd15
    } op_e;

    localparam logic [1:0] SEL_PC  = 2'b00;
    localparam logic [1:0] SEL_AR  = 2'b01;
    localparam logic [1:0] SEL_STK = 2'b10;
    localparam logic [1:0] SEL_D   = 2'b11;

    typedef enum logic [1:0] {
        DIN_BRANCH = 2'd0,
        DIN_MAP    = 2'd1,
        DIN_VEC    = 2'd2
    } din_src_e;

    typedef struct packed {
        logic [1:0] s;
        logic       zero_n;
        logic       cin;
        logic       re_n;
        logic       fe_n;
        logic       pup;
    } seq_ctl_t;

endpackage

// File: rtl/microseq_decode.sv
// Next-address op decode into Am2909 select/stack/register controls and counter actions.
// Latency: combinational. Backpressure: none; stall gating is applied by the parent.
module microseq_decode
    import microseq_pkg::*;
(
    input  op_e      op,
    input  logic     test,
    input  logic     cnt_zero,
    output seq_ctl_t ctl,
    output din_src_e din_src,
    output logic     cnt_load,
    output logic     cnt_dec
);

    always_comb begin
        ctl      = '{s: SEL_PC, zero_n: 1'b1, cin: 1'b1, re_n: 1'b1, fe_n: 1'b1, pup: 1'b0};
        din_src  = DIN_BRANCH;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (op)
            OP_JZ:   ctl.zero_n = 1'b0;
            OP_CJS:  if (test) begin ctl.fe_n = 1'b0; ctl.pup = 1'b1; ctl.s = SEL_D; end
            OP_JMAP: begin ctl.s = SEL_D; din_src = DIN_MAP; end
            OP_CJP:  if (test) ctl.s = SEL_D;
            OP_PUSH: begin ctl.fe_n = 1'b0; ctl.pup = 1'b1; cnt_load = test; end
            OP_JSRP: begin
                ctl.fe_n = 1'b0;
                ctl.pup  = 1'b1;
                ctl.s    = test ? SEL_D : SEL_AR;
            end
            OP_CJV:  begin din_src = DIN_VEC; if (test) ctl.s = SEL_D; end
            OP_JRP:  ctl.s = test ? SEL_D : SEL_AR;
            // Repeat-from-file: spin on the stack top without popping until the count expires.
            OP_RFCT: if (!cnt_zero) begin ctl.s = SEL_STK; cnt_dec = 1'b1; end
                     else ctl.fe_n = 1'b0;
            OP_RPCT: if (!cnt_zero) begin ctl.s = SEL_D; cnt_dec = 1'b1; end
            OP_CRTN: if (test) begin ctl.fe_n = 1'b0; ctl.s = SEL_STK; end
            OP_CJPP: if (test) begin ctl.fe_n = 1'b0; ctl.s = SEL_D; end
            OP_LDCT: begin ctl.re_n = 1'b0; cnt_load = 1'b1; end
            OP_LOOP: if (test) ctl.fe_n = 1'b0;
                     else ctl.s = SEL_STK;
            OP_CONT: ;
            OP_TWB:  if (test) ctl.fe_n = 1'b0;
                     else if (!cnt_zero) begin ctl.s = SEL_STK; cnt_dec = 1'b1; end
                     else begin ctl.fe_n = 1'b0; ctl.s = SEL_D; end
            default: ;
        endcase
    end

endmodule

// File: rtl/microseq_control.sv
// Microword pipeline register, loop counter and stall gating driving three cascaded Am2909s.
// Latency: one clock from uword_in to decoded controls. Backpressure: mem_busy holds pipe/cnt.
module microseq_control
    import microseq_pkg::*;
#(
    parameter int ADDR_W = microseq_pkg::ADDR_W,
    parameter int UW_W   = microseq_pkg::UW_W,
    parameter int NCOND  = microseq_pkg::NCOND
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [UW_W-1:0]      uword_in,
    input  logic [NCOND-1:0]     cond_in,
    input  logic [ADDR_W-1:0]    map_addr,
    input  logic [ADDR_W-1:0]    vec_addr,
    input  logic                 mem_busy,
    output logic [1:0]           seq_s,
    output logic                 seq_zero_n,
    output logic                 seq_cin,
    output logic                 seq_re_n,
    output logic                 seq_fe_n,
    output logic                 seq_pup,
    output logic [ADDR_W-1:0]    seq_din,
    output logic [UW_W-22:0]     uw_ctrl,
    output logic                 uw_valid
);

    logic [UW_W-1:0]   pipe;
    logic [ADDR_W-1:0] cnt;
    logic              valid;

    logic [ADDR_W-1:0] branch;
    logic [3:0]        cond_sel;
    logic [NCOND-1:0]  cond_eff;
    logic              test;
    logic              stall;

    seq_ctl_t          ctl;
    din_src_e          din_src;
    logic              cnt_load;
    logic              cnt_dec;

    assign branch   = pipe[BR_LSB +: ADDR_W];
    assign cond_sel = pipe[CSEL_LSB +: 4];
    assign cond_eff = {cond_in[NCOND-1:1], 1'b1};
    assign test     = cond_eff[cond_sel] ^ pipe[CPOL_BIT];
    assign stall    = mem_busy & ~reset;

    microseq_decode u_decode (
        .op       (op_e'(pipe[OP_LSB +: 4])),
        .test     (test),
        .cnt_zero (cnt == '0),
        .ctl      (ctl),
        .din_src  (din_src),
        .cnt_load (cnt_load),
        .cnt_dec  (cnt_dec)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            pipe  <= '0;
            cnt   <= '0;
            valid <= 1'b0;
        end else if (!mem_busy) begin
            pipe  <= uword_in;
            valid <= 1'b1;
            if (cnt_load)
                cnt <= branch;
            else if (cnt_dec)
                cnt <= cnt - ADDR_W'(1);
        end
    end

    always_comb begin
        case (din_src)
            DIN_MAP: seq_din = map_addr;
            DIN_VEC: seq_din = vec_addr;
            default: seq_din = branch;
        endcase
    end

    // A stalled sequencer re-presents its PC with no increment and no stack/AR side effects.
    assign seq_s      = stall ? SEL_PC : ctl.s;
    assign seq_cin    = stall ? 1'b0   : ctl.cin;
    assign seq_zero_n = stall ? 1'b1   : ctl.zero_n;
    assign seq_re_n   = stall ? 1'b1   : ctl.re_n;
    assign seq_fe_n   = stall ? 1'b1   : ctl.fe_n;
    assign seq_pup    = stall ? 1'b0   : ctl.pup;

    assign uw_ctrl    = pipe[UW_W-1:CTRL_LSB];
    assign uw_valid   = valid & ~stall;

endmodule

// File: doc/microseq_control.md
Name: microseq_control

Overview:
- Consumer/driver end of the microaddress interface. Registers the microword fetched from the control store at the Am2909 address. Decodes its 4-bit next-address op and a selected condition. Drives the select/stack/register/carry controls and branch data of three cascaded Am2909 slices (12-bit address).
- Owns the loop counter, the stall hold, and the pipeline register that feeds the datapath its control field.

Parameters:
- ADDR_W, 12, microaddress width (three 4-bit sequencer slices)
- UW_W, 56, microword width
- NCOND, 16, number of condition inputs

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- uword_in  in  UW_W  control-store output at the current sequencer address (asynchronous read)
- cond_in  in  NCOND  status/condition bits; bit 0 is forced to 1 internally ("always")
- map_addr  in  ADDR_W  opcode-map entry address
- vec_addr  in  ADDR_W  interrupt/trap vector address
- mem_busy  in  1  stall request, level-sensitive
- seq_s  out  2  source select {s1,s0}: 00 PC, 01 AR, 10 stack, 11 D
- seq_zero_n  out  1  0 forces the sequencer address to 0
- seq_cin  out  1  PC incrementer carry
- seq_re_n  out  1  0 loads AR from seq_din
- seq_fe_n  out  1  0 enables a stack operation
- seq_pup  out  1  1 push, 0 pop
- seq_din  out  ADDR_W  sequencer D input
- uw_ctrl  out  UW_W-21  datapath control field, pipe[UW_W-1:21]
- uw_valid  out  1  uw_ctrl is meaningful this cycle

Behaviour:
- Microword fields:
  - pipe[3:0]: op
  - pipe[7:4]: cond_sel
  - pipe[8]: cond_pol
  - pipe[20:9]: branch
- test = cond_in[cond_sel] ^ cond_pol, with cond_in[0] treated as 1. test is combinational from pipe and the live cond_in.
- Registers:
  - pipe (UW_W bits)
  - cnt (ADDR_W bits, loop counter)
  - valid
- Pipeline update, every edge when not stalled: pipe <= uword_in, valid <= 1.
- Reset (synchronous, active-high) while asserted:
  - pipe <= 0 (op JZ), cnt <= 0, valid <= 0.
  - Outputs decode from the cleared pipe: seq_zero_n=0, seq_cin=1, seq_fe_n=1, seq_re_n=1, seq_s=00, seq_din=0, uw_valid=0.
  - The first edge after release captures store[0]; the sequencer PC becomes 1.
  - Reset mid-stall or mid-loop overrides everything.
- Default outputs for every op: seq_cin=1, seq_zero_n=1, seq_fe_n=1, seq_re_n=1, seq_pup=0, seq_din=branch.
- "push" means fe_n=0, pup=1. "pop" means fe_n=0, pup=0.
- Ops (s value given; PC is the default):
  - 0 JZ: zero_n=0
  - 1 CJS: test ? push, D : PC
  - 2 JMAP: D, din=map_addr
  - 3 CJP: test ? D : PC
  - 4 PUSH: push, PC; if test, cnt <= branch
  - 5 JSRP: push; test ? D : AR
  - 6 CJV: test ? D : PC; din=vec_addr
  - 7 JRP: test ? D : AR
  - 8 RFCT: cnt≠0 ? stack (no pop), cnt-- : pop, PC
  - 9 RPCT: cnt≠0 ? D, cnt-- : PC
  - 10 CRTN: test ? pop, stack : PC
  - 11 CJPP: test ? pop, D : PC
  - 12 LDCT: PC; cnt <= branch; re_n=0 (AR <= branch)
  - 13 LOOP: test ? pop, PC : stack
  - 14 CONT: PC
  - 15 TWB:
    - cnt≠0: test ? (pop, PC) : (stack, cnt--)
    - cnt==0: test ? (pop, PC) : (pop, D)
- Counter boundaries:
  - cnt never decrements below 0 (no wrap).
  - Load and decrement never coincide; the decode makes them exclusive.
- Stall (mem_busy=1, reset=0):
  - pipe and cnt hold.
  - uw_valid=0 combinationally.
  - Outputs: seq_s=00, seq_cin=0, seq_zero_n=1, seq_fe_n=1, seq_re_n=1. The sequencer re-presents its PC and holds PC and stack.
  - The first cycle after mem_busy falls executes the held op normally.
- Latency: one clock from uword_in to its decoded controls. Controls are combinational from pipe and cond_in within that cycle.

Decomposition:
- Package microseq_pkg:
  - op encoding constants (0..15)
  - seq_s constants SEL_PC, SEL_AR, SEL_STK, SEL_D
  - field offsets OP_LSB, CSEL_LSB, CPOL_BIT, BR_LSB, CTRL_LSB=21
- Sub-module microseq_decode:
  - purely combinational
  - inputs: op, test, cnt_zero
  - outputs: seq controls, din_src, cnt_load, cnt_dec
- The top module holds pipe, cnt, valid, the condition mux, the din mux, and stall gating.

Test Plan:
- Reset held 3 cycles → seq_zero_n=0, seq_cin=1, uw_valid=0. After release, first captured word is store[0]; uw_valid=1.
- CJS (branch=0x123, cond_sel=0) → seq_s=11, seq_din=0x123, fe_n=0, pup=1. Then CRTN with test true → seq_s=10, fe_n=0, pup=0.
- LDCT branch=3, PUSH, then RFCT → seq_s=10 with fe_n=1 for exactly 3 passes (cnt 3→0). 4th pass pops and selects PC.
- TWB, cnt=2, test false,false,false → stack, stack (cnt 2→0), then pop+D. Repeat with test true on the first pass → immediate pop+PC.
- mem_busy high 4 cycles during CJP → seq_cin=0, seq_s=00, uw_valid=0, pipe/cnt unchanged. After release, CJP executes with the live test.
- JMAP with map_addr=0x7A0 → seq_din=0x7A0, seq_s=11. CJV test true with vec_addr=0xFF0 → seq_din=0xFF0.
